alu_result_arbiter: RTL
=======================

ALU_RESULT_ARBITER -- requirements
Module: alu_result_arbiter

Interface
REQ-001 Parameter DATA_SIZE, default 16: result width of adder and multiplier paths.
REQ-002 Parameter ID_SIZE, default 4: transaction ID width carried with each result.
REQ-003 Parameter OUT_WIDTH, default DATA_SIZE+ID_SIZE+1: FIFO_OUT word width, packed {tag, id, result}.
REQ-004 clk  input  1  single clock; all state updates on its rising edge.
REQ-005 rst_n  input  1  reset, synchronous, active-low.
REQ-006 a_res_valid  input  1  adder result pending; held high until acknowledged.
REQ-007 a_res  input  DATA_SIZE  adder result.
REQ-008 a_res_id  input  ID_SIZE  adder result ID.
REQ-009 a_res_ack  output  1  adder result accepted this cycle.
REQ-010 m_res_valid  input  1  multiplier result pending; held high until acknowledged.
REQ-011 m_res  input  DATA_SIZE  multiplier result (8x8 product, zero-extended).
REQ-012 m_res_id  input  ID_SIZE  multiplier result ID.
REQ-013 m_res_ack  output  1  multiplier result accepted this cycle.
REQ-014 full_out  input  1  FIFO_OUT full.
REQ-015 w_en_out  output  1  FIFO_OUT write strobe, one word per high cycle.
REQ-016 fifo_out_data  output  OUT_WIDTH  {tag(1=MUL,0=ADD), id, result}.

Function
REQ-017 Block SHALL own a single output holding register and a 2-state FSM: EMPTY, LOADED.
REQ-018 w_en_out SHALL equal (state==LOADED) & !full_out; fifo_out_data SHALL be the holding register.
REQ-019 can_load SHALL be (state==EMPTY) | !full_out; grants SHALL occur only when can_load.
REQ-020 Grant SHALL be combinational: a_res_ack/m_res_ack high in the same cycle the source is selected; at most one ack high per cycle.
REQ-021 Granted source's {tag,id,res} SHALL load the holding register at the end of the grant cycle; first write strobe appears the next cycle (latency 1 from valid to w_en_out when FIFO not full).
REQ-022 Transitions: EMPTY+grant->LOADED; LOADED&!full_out&grant->LOADED (reload, back-to-back, 1 word/cycle); LOADED&!full_out&no grant->EMPTY; LOADED&full_out->LOADED, register held, no ack.
REQ-023 Both valid same cycle: round-robin pointer SHALL select; pointer SHALL point to the non-granted source after every grant; single requester SHALL be granted regardless of pointer.
REQ-024 ack without valid SHALL never occur; valid dropping without ack is a protocol error, not handled.
REQ-025 No result SHALL be lost or duplicated: each ack maps to exactly one w_en_out cycle.

Reset
REQ-026 With rst_n low at a clock edge: state=EMPTY, holding register=0, RR pointer=ADD, so w_en_out=0 and fifo_out_data=0 from the following cycle.
REQ-027 a_res_ack and m_res_ack SHALL be 0 while rst_n is low.
REQ-028 Reset mid-operation SHALL discard the held word; sources still asserting valid SHALL be re-granted normally after release.

Configuration
REQ-029 Macro ALU_ARB_FIXED_PRIO_EN defined: fixed priority, ADD over MUL, no RR pointer logic.
REQ-030 Macro undefined: round-robin per REQ-023.

Structure
REQ-031 Shared package alu_pkg SHALL hold DATA_SIZE/ID_SIZE defaults, the tag constants (TAG_ADD=0, TAG_MUL=1) and the FSM state typedef.
REQ-032 Sub-module rr_arbiter_2 SHALL implement the 2-requester grant and pointer; top holds FSM and holding register.

Verification
REQ-033 Reset: rst_n=0 for 2 cycles with both valids high -> acks 0, w_en_out 0, fifo_out_data 0.
REQ-034 Single ADD: a_res=16'h1234, id=3, full_out=0 -> a_res_ack cycle N, w_en_out cycle N+1, fifo_out_data={0,4'h3,16'h1234}.
REQ-035 Contention: both valid for 4 cycles (ADD ids 1,2; MUL ids 5,6) -> writes ADD1,MUL5,ADD2,MUL6 (RR); with ALU_ARB_FIXED_PRIO_EN -> ADD1,ADD2,MUL5,MUL6.
REQ-036 Backpressure: LOADED with MUL id 7, full_out=1 for 5 cycles while a_res_valid=1 -> no acks, w_en_out 0, data stable; full_out drops -> MUL7 written, ADD acked same cycle, written next.
REQ-037 Reset mid-stall: LOADED, full_out=1, rst_n pulsed -> held word never written; pending a_res_valid re-acked after release.
REQ-038 Streaming: 32 alternating results, full_out=0 -> 32 writes in 33 cycles, IDs in order, no gaps.

Source files
------------

// File: rtl/alu_pkg.sv
// ---------------------------------------------------------------------------
// alu_pkg
// Shared definitions for the ALU result arbiter slice.
//   DATA_SIZE_DEF / ID_SIZE_DEF : default result and transaction-ID widths
//   TAG_ADD / TAG_MUL           : source tag stored in the MSB of each
//                                 output word (0 = adder, 1 = multiplier)
//   arb_state_e                 : output holding register FSM state
//   arb_src_e                   : source identifier, used by the round-robin
//                                 pointer
// ---------------------------------------------------------------------------
package alu_pkg;

  localparam int DATA_SIZE_DEF = 16;
  localparam int ID_SIZE_DEF   = 4;

  localparam logic TAG_ADD = 1'b0;
  localparam logic TAG_MUL = 1'b1;

  typedef enum logic {
    ST_EMPTY  = 1'b0,
    ST_LOADED = 1'b1
  } arb_state_e;

  typedef enum logic {
    SRC_ADD = 1'b0,
    SRC_MUL = 1'b1
  } arb_src_e;

endpackage

// File: rtl/rr_arbiter_2.sv
// ---------------------------------------------------------------------------
// rr_arbiter_2
// Two-requester grant logic for the ALU result arbiter. Grants are purely
// combinational so the requesting source sees its acknowledge in the same
// cycle it is selected. At most one grant is high per cycle.
//
// Configuration macro: ALU_ARB_FIXED_PRIO_EN
//   defined   : fixed priority, adder over multiplier, no pointer state
//   undefined : round-robin; after every grant the pointer moves to the
//               source that was not granted, so contention alternates
//
// Ports
//   clk       in   rising-edge clock (pointer update)
//   rst_n     in   synchronous active-low reset (pointer -> adder)
//   req_add   in   adder result pending
//   req_mul   in   multiplier result pending
//   grant_en  in   downstream can take a word this cycle
//   gnt_add   out  adder granted this cycle
//   gnt_mul   out  multiplier granted this cycle
// ---------------------------------------------------------------------------
module rr_arbiter_2
  import alu_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_add,
  input  logic req_mul,
  input  logic grant_en,
  output logic gnt_add,
  output logic gnt_mul
);

`ifdef ALU_ARB_FIXED_PRIO_EN

  // No pointer in this build; the clock and reset are kept on the port list
  // so both builds share one instantiation.
  logic unused_clk_rst;
  assign unused_clk_rst = clk ^ rst_n;

  always_comb begin
    gnt_add = 1'b0;
    gnt_mul = 1'b0;
    if (grant_en) begin
      gnt_add = req_add;
      gnt_mul = req_mul & ~req_add;
    end
  end

`else

  arb_src_e ptr_q;
  arb_src_e ptr_d;

  // A lone requester always wins; the pointer only breaks ties.
  always_comb begin
    gnt_add = 1'b0;
    gnt_mul = 1'b0;
    if (grant_en) begin
      if (req_add && req_mul) begin
        gnt_add = (ptr_q == SRC_ADD);
        gnt_mul = (ptr_q == SRC_MUL);
      end else begin
        gnt_add = req_add;
        gnt_mul = req_mul;
      end
    end
  end

  // Point at whichever source lost (or did not ask) after any grant.
  always_comb begin
    ptr_d = ptr_q;
    if (gnt_add) begin
      ptr_d = SRC_MUL;
    end else if (gnt_mul) begin
      ptr_d = SRC_ADD;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q <= SRC_ADD;
    end else begin
      ptr_q <= ptr_d;
    end
  end

`endif

endmodule

// File: rtl/alu_result_arbiter.sv
// ---------------------------------------------------------------------------
// alu_result_arbiter
// Merges adder and multiplier results into one output FIFO through a single
// holding register. A two-state FSM (EMPTY / LOADED) tracks whether the
// register holds a word not yet written. The register can be reloaded in the
// same cycle its current word is written, giving one word per cycle when the
// FIFO is not full.
//
// Configuration macro: ALU_ARB_FIXED_PRIO_EN (see rr_arbiter_2); when
// undefined, simultaneous requests are served round-robin.
//
// Ports
//   clk            in   rising-edge clock
//   rst_n          in   synchronous active-low reset
//   a_res_valid    in   adder result pending (held until acked)
//   a_res          in   adder result [DATA_SIZE]
//   a_res_id       in   adder result ID [ID_SIZE]
//   a_res_ack      out  adder result accepted this cycle
//   m_res_valid    in   multiplier result pending (held until acked)
//   m_res          in   multiplier result [DATA_SIZE]
//   m_res_id       in   multiplier result ID [ID_SIZE]
//   m_res_ack      out  multiplier result accepted this cycle
//   full_out       in   output FIFO full
//   w_en_out       out  output FIFO write strobe
//   fifo_out_data  out  {tag, id, result} [OUT_WIDTH]
// ---------------------------------------------------------------------------
module alu_result_arbiter
  import alu_pkg::*;
#(
  parameter int DATA_SIZE = DATA_SIZE_DEF,
  parameter int ID_SIZE   = ID_SIZE_DEF,
  parameter int OUT_WIDTH = DATA_SIZE + ID_SIZE + 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 a_res_valid,
  input  logic [DATA_SIZE-1:0] a_res,
  input  logic [ID_SIZE-1:0]   a_res_id,
  output logic                 a_res_ack,
  input  logic                 m_res_valid,
  input  logic [DATA_SIZE-1:0] m_res,
  input  logic [ID_SIZE-1:0]   m_res_id,
  output logic                 m_res_ack,
  input  logic                 full_out,
  output logic                 w_en_out,
  output logic [OUT_WIDTH-1:0] fifo_out_data
);

  localparam int WORD_W = DATA_SIZE + ID_SIZE + 1;

  arb_state_e           state_q;
  arb_state_e           state_d;
  logic [OUT_WIDTH-1:0] hold_q;
  logic [OUT_WIDTH-1:0] hold_d;

  logic              can_load;
  logic              grant_en;
  logic              gnt_add;
  logic              gnt_mul;
  logic [WORD_W-1:0] add_word;
  logic [WORD_W-1:0] mul_word;

  // The register may take a new word if it is empty or its current word
  // leaves this cycle. Reset masks grants so no ack is issued while rst_n is
  // low.
  assign can_load = (state_q == ST_EMPTY) | ~full_out;
  assign grant_en = can_load & rst_n;

  assign add_word = {TAG_ADD, a_res_id, a_res};
  assign mul_word = {TAG_MUL, m_res_id, m_res};

  rr_arbiter_2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_add  (a_res_valid),
    .req_mul  (m_res_valid),
    .grant_en (grant_en),
    .gnt_add  (gnt_add),
    .gnt_mul  (gnt_mul)
  );

  assign a_res_ack     = gnt_add;
  assign m_res_ack     = gnt_mul;
  assign w_en_out      = (state_q == ST_LOADED) & ~full_out;
  assign fifo_out_data = hold_q;

  // A grant always (re)loads the register; without one, a word that was just
  // written empties it, and a stalled word stays put.
  always_comb begin
    state_d = state_q;
    hold_d  = hold_q;
    if (gnt_add) begin
      state_d = ST_LOADED;
      hold_d  = OUT_WIDTH'(add_word);
    end else if (gnt_mul) begin
      state_d = ST_LOADED;
      hold_d  = OUT_WIDTH'(mul_word);
    end else if ((state_q == ST_LOADED) && !full_out) begin
      state_d = ST_EMPTY;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_EMPTY;
      hold_q  <= '0;
    end else begin
      state_q <= state_d;
      hold_q  <= hold_d;
    end
  end

endmodule
